instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Instruction fetch/issue sequencer that produces the 4-bit opcode and instruction word consumed by the control decoder.
- Holds the PC and reads 16-bit instructions from instruction memory over a request/valid interface.
- Presents each instruction downstream with a valid/ready handshake.
- Stalls on branch-class opcodes until execute resolves them; halts on the stop opcode.

Parameters:
ADDR_W, 8, PC / instruction-memory address width; PC wraps modulo 2^ADDR_W
INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1 -: 4]
RESET_PC, 0, PC value after reset and on restart from HALT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin fetching (IDLE) or restart from RESET_PC (HALT); ignored in other states
imem_req  output  1  one-cycle read request to instruction memory
imem_addr  output  ADDR_W  read address, valid while imem_req=1
imem_rvalid  input  1  read data valid, any latency ≥1 cycle after imem_req
imem_rdata  input  INSTR_W  instruction word
instr_valid  output  1  instruction presented to decode
instr_ready  input  1  decode accepts instruction
instr  output  INSTR_W  registered instruction word
opcode  output  4  instr[INSTR_W-1 -: 4], to control decoder
instr_pc  output  ADDR_W  address of the presented instruction
br_resolve  input  1  execute reports branch outcome (single-cycle pulse)
br_taken  input  1  qualified by br_resolve; 1 = redirect
br_target  input  ADDR_W  redirect address, qualified by br_resolve & br_taken
halted  output  1  high while in HALT

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset, including mid-operation: state=IDLE, pc=RESET_PC. imem_req=0, imem_addr=0, instr_valid=0, instr=0, opcode=0, instr_pc=0, halted=0. Any outstanding imem response is discarded.
- All outputs are registered. imem_addr=pc during FETCH, otherwise holds its last value.
- States: IDLE, FETCH, WAIT, ISSUE, BR_WAIT, HALT.
- IDLE: start=1 → FETCH.
- FETCH: imem_req=1 for exactly one cycle → WAIT.
- WAIT: imem_req=0. On imem_rvalid: instr<=imem_rdata, instr_pc<=pc, pc<=pc+1 (wrap 2^ADDR_W-1 → 0) → ISSUE. imem_rvalid in any other state is ignored.
- ISSUE: instr_valid=1. instr, opcode and instr_pc stay stable until instr_valid & instr_ready. On that handshake, instr_valid falls the next cycle and the next state is:
  - opcode==4'b1111 (stop) → HALT
  - opcode in 4'b1000..4'b1110 (beq, bne, bgt, blt, bge, blte, jmp) → BR_WAIT, except when br_resolve=1 in the handshake cycle: then resolve immediately (pc<=br_target if br_taken) → FETCH
  - otherwise (plus, min, and, or, ldw, stw, plusi, lui) → FETCH
- BR_WAIT: no fetch issued. On br_resolve: pc<=br_target if br_taken, else pc unchanged (already pc+1) → FETCH. br_resolve in IDLE, FETCH, WAIT or HALT is ignored. br_resolve in ISSUE counts only in the branch-class handshake cycle.
- HALT: halted=1, no requests. start=1 → pc<=RESET_PC, halted<=0 → FETCH.
- Throughput: at most one instruction per 3 cycles with 1-cycle memory latency (FETCH, WAIT, ISSUE). No prefetch and no speculation.
- Every fetched instruction is issued exactly once; none are dropped or duplicated.

Optional Feature:
Macro IFU_PERF_CNT_EN.
- Defined: adds output issue_count[31:0] and output stall_count[31:0], both reset to 0.
  - issue_count increments on each instr_valid & instr_ready.
  - stall_count increments each cycle in BR_WAIT, or in ISSUE with instr_ready=0.
  - Both saturate at 32'hFFFF_FFFF. Neither clears on restart from HALT.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- Straight-line program: imem[0..2] = 16'h0123, 16'h1456, 16'hF000; start pulse; 1-cycle memory; instr_ready=1 → instructions issued in order with instr_pc 0, 1, 2 and opcodes 0, 1, F; halted=1 after the third handshake; imem_req fires exactly 3 times.
- Backpressure: instr_ready=0 for 5 cycles in ISSUE → instr stays 16'h0123, instr_valid stays 1, no imem_req; ready=1 → single handshake, then FETCH at pc=1.
- Branch: beq (16'h8xxx) at pc=4, br_resolve with br_taken=1 and br_target=8'h20 two cycles later → next imem_addr=8'h20; repeat with br_taken=0 → next imem_addr=5; br_resolve in the handshake cycle → no BR_WAIT cycles.
- Wrap and variable latency: RESET_PC=8'hFF, memory latency 3 → first fetch at 8'hFF, second at 8'h00; stray imem_rvalid in BR_WAIT is ignored.
- Reset mid-WAIT: assert rst while awaiting imem_rvalid → all outputs 0 and state IDLE immediately; a late rvalid is ignored; the next start fetches RESET_PC.
- With IFU_PERF_CNT_EN: the straight-line program with 2 cycles of backpressure → issue_count=3, stall_count=2; restart from HALT leaves both unchanged.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch/issue sequencer: FETCH->WAIT->ISSUE per instruction (3 cycles at 1-cycle imem), stalls on branches and halts on stop.
// Holds instruction stable while instr_ready=0; optional IFU_PERF_CNT_EN adds saturating issue/stall counters.
module instr_fetch_unit #(
  parameter int              ADDR_W   = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               br_resolve,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]        issue_count,
  output logic [31:0]        stall_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_BR_WAIT, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                imem_req_q, imem_req_d;
  logic                instr_valid_q, instr_valid_d;
  logic                halted_q, halted_d;
  logic [3:0]          op;
  logic                hs;

  assign op = instr_q[INSTR_W-1 -: 4];
  assign hs = (state_q == S_ISSUE) && instr_valid_q && instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      imem_addr_q   <= '0;
      instr_pc_q    <= '0;
      instr_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_addr_q   <= imem_addr_d;
      instr_pc_q    <= instr_pc_d;
      instr_q       <= instr_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + ADDR_W'(1);
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hs) begin
          if (op == 4'hF) begin
            state_d = S_HALT;
          end else if (op[3]) begin
            // A resolve arriving with the handshake skips BR_WAIT entirely.
            if (br_resolve) begin
              if (br_taken) pc_d = br_target;
              state_d = S_FETCH;
            end else begin
              state_d = S_BR_WAIT;
            end
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_BR_WAIT: begin
        if (br_resolve) begin
          if (br_taken) pc_d = br_target;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    imem_req_d    = (state_d == S_FETCH);
    imem_addr_d   = (state_d == S_FETCH) ? pc_d : imem_addr_q;
    instr_valid_d = (state_d == S_ISSUE);
    halted_d      = (state_d == S_HALT);
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign opcode      = op;
  assign instr_pc    = instr_pc_q;
  assign halted      = halted_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;
  logic        stall_cond;

  assign stall_cond = (state_q == S_BR_WAIT) || ((state_q == S_ISSUE) && !instr_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (hs && (issue_cnt_q != 32'hFFFF_FFFF)) issue_cnt_q <= issue_cnt_q + 32'd1;
      if (stall_cond && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign issue_count = issue_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule
